sha256_digest_tx: RTL and testbench

SHA256_DIGEST_TX -- requirements
Module: sha256_digest_tx

---
 rtl/sha256_pkg.sv | 29 ++
 rtl/sha256_digest_tx.sv | 103 ++++++++++
 tb/tb_sha256_digest_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 digest transmitter.
package sha256_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned L          = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StLoad,
    StSend
  } state_e;

  // SHA-256 initial hash values, H0 in the top word.
  localparam logic [DATA_WIDTH*L-1:0] ShaInitHash = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [DATA_WIDTH-1:0] bswap(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
      r[8*b +: 8] = w[int'(DATA_WIDTH) - 8 - 8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_digest_tx.sv
// Streams a captured SHA-256 digest one word per transfer over a valid/ready port.
// Define SHA256_DIGEST_BSWAP_EN to byte-reverse each outgoing word.
module sha256_digest_tx #(
  parameter int unsigned DATA_WIDTH = sha256_pkg::DATA_WIDTH,
  parameter int unsigned L          = sha256_pkg::L
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  output logic                    o_RE,
  input  logic [DATA_WIDTH*L-1:0] i_hash,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done
);

  import sha256_pkg::*;

  localparam int unsigned       IdxW    = (L > 1) ? $clog2(L) : 1;
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(L - 1);

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH*L-1:0] hash_q, hash_d;
  logic                    done_q, done_d;
  logic                    re, valid;
  logic [DATA_WIDTH-1:0]   words [L];
  logic [DATA_WIDTH-1:0]   word_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hash_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hash_q  <= hash_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hash_d  = hash_q;
    done_d  = 1'b0;
    re      = 1'b0;
    valid   = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start) state_d = StRead;
      end
      StRead: begin
        re      = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        hash_d  = i_hash;
        idx_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        valid = 1'b1;
        if (i_ready) begin
          // Terminate on the compare; the index never wraps within a digest.
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Word 0 is H0, held in the most significant slice of the capture register.
  always_comb begin
    for (int k = 0; k < int'(L); k++) begin
      words[k] = hash_q[DATA_WIDTH*(L-1-k) +: DATA_WIDTH];
    end
  end

`ifdef SHA256_DIGEST_BSWAP_EN
  assign word_sel = bswap(words[idx_q]);
`else
  assign word_sel = words[idx_q];
`endif

  assign o_RE    = re;
  assign o_valid = valid;
  assign o_data  = valid ? word_sel : '0;
  assign o_last  = valid && (idx_q == LastIdx);
  assign o_busy  = (state_q != StIdle);
  assign o_done  = done_q;

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Directed bench for sha256_digest_tx; honours SHA256_DIGEST_BSWAP_EN in its reference words.
module tb_sha256_digest_tx;

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 8;

  localparam logic [255:0] Iv = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] Abc = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start;
  logic             o_RE;
  logic [DW*NW-1:0] i_hash;
  logic [DW-1:0]    o_data;
  logic             o_valid;
  logic             i_ready;
  logic             o_last;
  logic             o_busy;
  logic             o_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sha256_digest_tx #(
    .DATA_WIDTH(DW),
    .L         (NW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(i_start),
    .o_RE   (o_RE),
    .i_hash (i_hash),
    .o_data (o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_last (o_last),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  function automatic logic [31:0] ref_word(input logic [255:0] h, input int k);
    logic [31:0] w;
    w = h[255 - 32*k -: 32];
`ifdef SHA256_DIGEST_BSWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flags packed as {o_RE, o_valid, o_last, o_busy, o_done}.
  task automatic chk_flags(input string tag, input logic [4:0] exp);
    chk(tag, {27'b0, o_RE, o_valid, o_last, o_busy, o_done}, {27'b0, exp});
  endtask

  // Pulses i_start from IDLE (or the o_done cycle) and walks READ and LOAD.
  task automatic launch(input string tag, input logic [255:0] h);
    i_hash  = h;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk_flags({tag, "_read"}, 5'b10010);
    tick;
    chk_flags({tag, "_load"}, 5'b00010);
    tick;
    // Captured at the LOAD edge; later changes must not reach o_data.
    i_hash = {8{32'hdeadbeef}};
  endtask

  // Full-rate stream from the first SEND cycle; optional i_start pulse at word pulse_at.
  task automatic stream_ready(input string tag, input logic [255:0] h, input int pulse_at);
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_start = (k == pulse_at);
      chk($sformatf("%s_w%0d", tag, k), o_data, ref_word(h, k));
      chk($sformatf("%s_vl%0d", tag, k), {30'b0, o_valid, o_last}, {30'b0, 1'b1, k == 7});
      tick;
    end
    i_start = 1'b0;
    chk_flags({tag, "_done"}, 5'b00001);
    chk({tag, "_done_data"}, o_data, 32'h0);
  endtask

  initial begin
    logic [3:0] pat;
    int         idx;

    rst_n   = 1'b0;
    i_start = 1'b0;
    i_ready = 1'b0;
    i_hash  = '0;
    tick;
    tick;
    chk_flags("rst", 5'b00000);
    chk("rst_data", o_data, 32'h0);
    rst_n = 1'b1;
    tick;
    chk_flags("idle", 5'b00000);

    // Initial hash values at full rate.
    launch("t1", Iv);
    stream_ready("t1", Iv, -1);
    tick;
    chk_flags("t1_idle", 5'b00000);

    // abc digest with ready pattern 1,0,0,1 repeating.
    launch("t2", Abc);
    pat = 4'b1001;
    idx = 0;
    for (int c = 0; c < 64 && idx < 8; c++) begin
      i_ready = pat[c % 4];
      chk($sformatf("t2_w%0d_c%0d", idx, c), o_data, ref_word(Abc, idx));
      chk($sformatf("t2_vl_c%0d", c), {30'b0, o_valid, o_last}, {30'b0, 1'b1, idx == 7});
      if (i_ready) idx++;
      tick;
    end
    chk("t2_count", 32'(idx), 32'd8);
    chk_flags("t2_done", 5'b00001);
    i_ready = 1'b1;
    tick;

    // Start mid-SEND is dropped and not queued.
    launch("t3a", Iv);
    stream_ready("t3a", Iv, 2);
    tick;
    chk_flags("t3_noqueue", 5'b00000);

    // Start coincident with o_done chains straight into READ.
    launch("t3b", Abc);
    stream_ready("t3b", Abc, -1);
    launch("t3c", Iv);
    stream_ready("t3c", Iv, -1);
    tick;

    // Reset after three transfers truncates without o_done.
    launch("t4", Abc);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_w%0d", k), o_data, ref_word(Abc, k));
      tick;
    end
    rst_n = 1'b0;
    tick;
    chk_flags("t4_rst", 5'b00000);
    chk("t4_rst_data", o_data, 32'h0);
    rst_n = 1'b1;
    tick;
    chk_flags("t4_nodone", 5'b00000);
    launch("t4b", Iv);
    stream_ready("t4b", Iv, -1);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
